tone_sequencer: RTL

Sequencer that plays a short programmed schedule of divided-clock tones on a single output pin. It consumes the 8-tap binary clock-divider bank (tap i = clk/2^(i+1)) and holds up to NUM_SLOTS entries of {tap select, duration}. It steps through those entries automatically, optionally looping. It sits between the divider bank and the user output mux.

---
 rtl/tone_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tone_sequencer
// Description : Plays a programmed schedule of divided-clock tones on one pin.
//               Each schedule slot holds {tap select, duration}. The duration
//               is counted in ticks, where a tick is a rising edge of taps[7].
//               Playback steps through the slots and can optionally loop.
//               Optional build macro TONE_SEQ_GAP_EN inserts one silent tick
//               period after every played slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int NUM_SLOTS = 4,
  parameter int DUR_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   taps,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_addr,
  input  logic [3+DUR_W-1:0]           wr_data,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  output logic                         sig_out,
  output logic                         busy,
  output logic [$clog2(NUM_SLOTS)-1:0] slot,
  output logic                         done
);

  localparam int AW = $clog2(NUM_SLOTS);
  localparam int WW = 3 + DUR_W;

  localparam logic [AW-1:0]    LAST_SLOT = AW'(NUM_SLOTS - 1);
  localparam logic [AW-1:0]    SLOT_ONE  = AW'(1);
  localparam logic [DUR_W-1:0] CNT_ONE   = DUR_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    PLAY  = 3'd2,
`ifdef TONE_SEQ_GAP_EN
    GAP   = 3'd4,
`endif
    ADV   = 3'd3
  } state_t;

  state_t           state;
  logic [WW-1:0]    ram [NUM_SLOTS];
  logic             tap7_q;
  logic [DUR_W-1:0] cnt;
  logic [2:0]       cur_tap;

  logic             tick;
  logic [WW-1:0]    rd_entry;
  logic [2:0]       rd_tap;
  logic [DUR_W-1:0] rd_dur;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign tick     = taps[7] & ~tap7_q;
  assign rd_entry = ram[slot];
  assign rd_tap   = rd_entry[WW-1:DUR_W];
  assign rd_dur   = rd_entry[DUR_W-1:0];

  // Registered copy of the slowest tap, used to detect its rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap7_q <= 1'b0;
    end else begin
      tap7_q <= taps[7];
    end
  end

  // Schedule storage; writes are only acknowledged while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ram[i] <= '0;
      end
    end else if (wr_valid && wr_ready) begin
      ram[wr_addr] <= wr_data;
    end
  end

  // Playback state machine with registered tone output and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      slot    <= '0;
      cnt     <= '0;
      cur_tap <= '0;
      sig_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      sig_out <= 1'b0;
      if ((state != IDLE) && stop) begin
        // Abort: slot keeps its last value so software can see where it stopped.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              slot  <= '0;
              state <= FETCH;
            end
          end
          FETCH: begin
            cur_tap <= rd_tap;
            cnt     <= rd_dur;
            state   <= (rd_dur == '0) ? ADV : PLAY;
          end
          PLAY: begin
            sig_out <= taps[cur_tap];
            if (tick) begin
              cnt <= cnt - CNT_ONE;
              if (cnt == CNT_ONE) begin
                // Last tick of the slot: go silent immediately.
                sig_out <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
                state   <= GAP;
`else
                state   <= ADV;
`endif
              end
            end
          end
`ifdef TONE_SEQ_GAP_EN
          GAP: begin
            if (tick) begin
              state <= ADV;
            end
          end
`endif
          ADV: begin
            if (slot != LAST_SLOT) begin
              slot  <= slot + SLOT_ONE;
              state <= FETCH;
            end else if (loop) begin
              slot  <= '0;
              state <= FETCH;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
